reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (min 2).
REQ-003 SHALL have parameter AW, default 3, index width = clog2(DEPTH).
REQ-004 SHALL use one clock and asynchronous active-low reset: CLK in 1, rising-edge clock; RESET_N in 1, asynchronous active-low reset.
REQ-005 SHALL have WR_EN in 1 (write strobe), N_REG_W in AW (write index), WR_DATA in WIDTH (write data).
REQ-006 SHALL have LOCK_EN in 1 (mark register pending) and N_REG_L in AW (lock index).
REQ-007 SHALL have, per read port x in {A,B}:
- RD_EN_x in 1, read request;
- N_REG_x in AW, read index;
- N_REG_OUT_x out AW, echoed index;
- REG_OUT_x out WIDTH, read data;
- VALID_x out 1, data valid;
- BUSY_x out 1, read refused, register locked;
- ERR_x out 1, index out of range.
REQ-008 SHALL have BUSY_MAP out DEPTH, current lock bit per register.

Function
REQ-009 SHALL hold DEPTH x WIDTH storage plus a DEPTH-bit lock map.
REQ-010 SHALL write WR_DATA to reg[N_REG_W] on a CLK edge with WR_EN=1 and N_REG_W<DEPTH; SHALL clear lock[N_REG_W] on the same edge.
REQ-011 SHALL set lock[N_REG_L] on a CLK edge with LOCK_EN=1 and N_REG_L<DEPTH; on the same index, simultaneous lock and write SHALL write the data and leave the lock set (lock wins).
REQ-012 SHALL update port x outputs registered, 1-cycle latency, after a CLK edge with RD_EN_x=1:
- N_REG_OUT_x <= N_REG_x;
- exactly one of VALID_x, BUSY_x, ERR_x = 1.
REQ-013 SHALL resolve each read in this priority:
1. index>=DEPTH: ERR_x=1, REG_OUT_x<=0.
2. same-edge write to same index: VALID_x=1, REG_OUT_x<=WR_DATA (bypass, lock ignored).
3. lock set: BUSY_x=1, REG_OUT_x holds.
4. otherwise: VALID_x=1, REG_OUT_x<=reg[index].
REQ-014 SHALL drive VALID_x, BUSY_x and ERR_x to 0 after any edge with RD_EN_x=0; REG_OUT_x and N_REG_OUT_x SHALL hold.
REQ-015 SHALL let ports A and B read the same or different indices independently in the same cycle.
REQ-016 SHALL ignore writes and locks to index>=DEPTH, with no state change.
REQ-017 SHALL drive BUSY_MAP directly from the lock register state, i.e. the post-edge value.

Reset
REQ-018 SHALL, while RESET_N=0, immediately force all registers to 0, all lock bits to 0, all REG_OUT_x and N_REG_OUT_x to 0, and VALID_x, BUSY_x, ERR_x to 0.
REQ-019 SHALL discard in-flight reads and writes when reset is asserted mid-operation; the first edge after release SHALL behave as from reset state.

Structure
REQ-020 SHALL take WIDTH and DEPTH defaults, and the result encoding VALID/BUSY/ERR, from shared package cpu15_pkg.
REQ-021 SHALL implement each read port as one instance of sub-module reg_bank_rdport, instantiated twice, containing the priority logic and output registers.

Verification
REQ-022 SHALL cover write-then-read: write 16'h6535 to reg0 … 16'h808d to reg7, then RD_EN_A=1 with N_REG_A stepping 0..7 -> each value appears one cycle later with VALID_A=1 and N_REG_OUT_A matching the index.
REQ-023 SHALL cover bypass: WR_EN=1, N_REG_W=3, WR_DATA=16'habcd, RD_EN_B=1, N_REG_B=3 on the same edge, reg3 previously 16'h0000 -> REG_OUT_B=16'habcd, VALID_B=1.
REQ-024 SHALL cover lock: LOCK_EN, N_REG_L=5, then read A index 5 -> BUSY_A=1, VALID_A=0, BUSY_MAP=8'h20; then write 16'h1234 to reg5, next read -> VALID_A=1, 16'h1234.
REQ-025 SHALL cover simultaneous lock and write: lock and write on reg2 on the same edge -> BUSY_MAP[2]=1, reg2 holds the new data.
REQ-026 SHALL cover out-of-range: DEPTH=6, read index 7 -> ERR_A=1, REG_OUT_A=0; write to index 6 -> no storage change.
REQ-027 SHALL cover reset mid-operation: RESET_N low between edges while VALID_A=1 -> all outputs 0 immediately; a read of reg0 after release returns 16'h0000.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared definitions for the cpu15 register bank: default geometry and the
// read-result encoding used by the read ports.
package cpu15_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    RD_NONE  = 2'd0,
    RD_VALID = 2'd1,
    RD_BUSY  = 2'd2,
    RD_ERR   = 2'd3
  } rd_res_e;

  function automatic logic idx_in_range(int idx, int depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port: resolves a request against range, same-edge
// write bypass and the lock bit, then holds the result until the next request.
module reg_bank_rdport
  import cpu15_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_idx_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [WIDTH-1:0] rd_data_i,
  input  logic             locked_i,
  output logic [AW-1:0]    n_reg_out_o,
  output logic [WIDTH-1:0] reg_out_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  rd_res_e          res_q, res_d;

  always_comb begin
    res_d  = RD_NONE;
    idx_d  = idx_q;
    data_d = data_q;
    if (rd_en_i) begin
      idx_d = rd_idx_i;
      if (!idx_in_range(int'(rd_idx_i), DEPTH)) begin
        res_d  = RD_ERR;
        data_d = '0;
      end else if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
        // bypass: the write lands on this edge, so the lock is irrelevant
        res_d  = RD_VALID;
        data_d = wr_data_i;
      end else if (locked_i) begin
        res_d  = RD_BUSY;
      end else begin
        res_d  = RD_VALID;
        data_d = rd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q  <= RD_NONE;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      res_q  <= res_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign n_reg_out_o = idx_q;
  assign reg_out_o   = data_q;
  assign valid_o     = (res_q == RD_VALID);
  assign busy_o      = (res_q == RD_BUSY);
  assign err_o       = (res_q == RD_ERR);

endmodule

// File: rtl/reg_bank.sv
// Register bank with per-register lock bits, one write port, one lock port
// and two independent registered read ports.
module reg_bank
  import cpu15_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             WR_EN,
  input  logic [AW-1:0]    N_REG_W,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             LOCK_EN,
  input  logic [AW-1:0]    N_REG_L,
  input  logic             RD_EN_A,
  input  logic [AW-1:0]    N_REG_A,
  output logic [AW-1:0]    N_REG_OUT_A,
  output logic [WIDTH-1:0] REG_OUT_A,
  output logic             VALID_A,
  output logic             BUSY_A,
  output logic             ERR_A,
  input  logic             RD_EN_B,
  input  logic [AW-1:0]    N_REG_B,
  output logic [AW-1:0]    N_REG_OUT_B,
  output logic [WIDTH-1:0] REG_OUT_B,
  output logic             VALID_B,
  output logic             BUSY_B,
  output logic             ERR_B,
  output logic [DEPTH-1:0] BUSY_MAP
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] lock_q, lock_d;
  logic [DEPTH-1:0] wr_hit, lock_hit;

  // Out-of-range indices match no register, so they are dropped naturally.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      assign wr_hit[gi]   = WR_EN   && (int'(N_REG_W) == gi);
      assign lock_hit[gi] = LOCK_EN && (int'(N_REG_L) == gi);
      assign regs_d[gi]   = wr_hit[gi] ? WR_DATA : regs_q[gi];
      assign lock_d[gi]   = lock_hit[gi] | (lock_q[gi] & ~wr_hit[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q <= '{default: '0};
      lock_q <= '0;
    end else begin
      regs_q <= regs_d;
      lock_q <= lock_d;
    end
  end

  assign BUSY_MAP = lock_q;

  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .rd_en_i    (RD_EN_A),
    .rd_idx_i   (N_REG_A),
    .wr_en_i    (WR_EN),
    .wr_idx_i   (N_REG_W),
    .wr_data_i  (WR_DATA),
    .rd_data_i  (regs_q[N_REG_A]),
    .locked_i   (lock_q[N_REG_A]),
    .n_reg_out_o(N_REG_OUT_A),
    .reg_out_o  (REG_OUT_A),
    .valid_o    (VALID_A),
    .busy_o     (BUSY_A),
    .err_o      (ERR_A)
  );

  reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .rd_en_i    (RD_EN_B),
    .rd_idx_i   (N_REG_B),
    .wr_en_i    (WR_EN),
    .wr_idx_i   (N_REG_W),
    .wr_data_i  (WR_DATA),
    .rd_data_i  (regs_q[N_REG_B]),
    .locked_i   (lock_q[N_REG_B]),
    .n_reg_out_o(N_REG_OUT_B),
    .reg_out_o  (REG_OUT_B),
    .valid_o    (VALID_B),
    .busy_o     (BUSY_B),
    .err_o      (ERR_B)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: two instances (DEPTH=8 and DEPTH=6) share
// the same stimulus and are checked against a behavioural model.
module tb_reg_bank;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        WR_EN, LOCK_EN, RD_EN_A, RD_EN_B;
  logic [2:0]  N_REG_W, N_REG_L, N_REG_A, N_REG_B;
  logic [15:0] WR_DATA;

  logic [2:0]  o_idx  [2][2];
  logic [15:0] o_data [2][2];
  logic        o_v [2][2];
  logic        o_b [2][2];
  logic        o_e [2][2];
  logic [7:0]  map0;
  logic [5:0]  map1;

  always #5 CLK = ~CLK;

  reg_bank dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_EN(WR_EN), .N_REG_W(N_REG_W), .WR_DATA(WR_DATA),
    .LOCK_EN(LOCK_EN), .N_REG_L(N_REG_L),
    .RD_EN_A(RD_EN_A), .N_REG_A(N_REG_A), .N_REG_OUT_A(o_idx[0][0]), .REG_OUT_A(o_data[0][0]),
    .VALID_A(o_v[0][0]), .BUSY_A(o_b[0][0]), .ERR_A(o_e[0][0]),
    .RD_EN_B(RD_EN_B), .N_REG_B(N_REG_B), .N_REG_OUT_B(o_idx[0][1]), .REG_OUT_B(o_data[0][1]),
    .VALID_B(o_v[0][1]), .BUSY_B(o_b[0][1]), .ERR_B(o_e[0][1]),
    .BUSY_MAP(map0)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6), .AW(3)) dut6 (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_EN(WR_EN), .N_REG_W(N_REG_W), .WR_DATA(WR_DATA),
    .LOCK_EN(LOCK_EN), .N_REG_L(N_REG_L),
    .RD_EN_A(RD_EN_A), .N_REG_A(N_REG_A), .N_REG_OUT_A(o_idx[1][0]), .REG_OUT_A(o_data[1][0]),
    .VALID_A(o_v[1][0]), .BUSY_A(o_b[1][0]), .ERR_A(o_e[1][0]),
    .RD_EN_B(RD_EN_B), .N_REG_B(N_REG_B), .N_REG_OUT_B(o_idx[1][1]), .REG_OUT_B(o_data[1][1]),
    .VALID_B(o_v[1][1]), .BUSY_B(o_b[1][1]), .ERR_B(o_e[1][1]),
    .BUSY_MAP(map1)
  );

  typedef struct {
    int          inst;
    int          port;
    logic [2:0]  idx;
    logic [15:0] data;
    logic [2:0]  flags;  // {valid, busy, err}
  } exp_t;

  exp_t        sb[$];
  int          depth_m [2] = '{8, 6};
  logic [15:0] m_regs [2][8];
  logic [7:0]  m_lock [2];
  logic [15:0] m_data [2][2];
  logic [2:0]  m_idx  [2][2];
  int          n_checks = 0;
  int          n_errors = 0;
  int          txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = '0;
      for (int r = 0; r < 8; r++) m_regs[k][r] = '0;
      for (int p = 0; p < 2; p++) begin
        m_data[k][p] = '0;
        m_idx[k][p]  = '0;
      end
    end
  endtask

  task automatic idle();
    WR_EN = 0; LOCK_EN = 0; RD_EN_A = 0; RD_EN_B = 0;
    N_REG_W = 0; N_REG_L = 0; N_REG_A = 0; N_REG_B = 0; WR_DATA = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s_i%0dp%0d_data", tag, k, p), {16'b0, o_data[k][p]}, 32'h0);
        check($sformatf("%s_i%0dp%0d_idx", tag, k, p), {29'b0, o_idx[k][p]}, 32'h0);
        check($sformatf("%s_i%0dp%0d_flags", tag, k, p),
              {29'b0, o_v[k][p], o_b[k][p], o_e[k][p]}, 32'h0);
      end
    check({tag, "_map0"}, {24'b0, map0}, 32'h0);
    check({tag, "_map1"}, {26'b0, map1}, 32'h0);
  endtask

  // Predict this edge's results, advance the model, clock, then compare.
  task automatic tick();
    exp_t        e;
    logic        en;
    logic [2:0]  idx;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        en  = (p == 0) ? RD_EN_A : RD_EN_B;
        idx = (p == 0) ? N_REG_A : N_REG_B;
        e.flags = 3'b000;
        if (en) begin
          m_idx[k][p] = idx;
          if (int'(idx) >= depth_m[k]) begin
            e.flags = 3'b001;
            m_data[k][p] = '0;
          end else if (WR_EN && N_REG_W == idx) begin
            e.flags = 3'b100;
            m_data[k][p] = WR_DATA;
          end else if (m_lock[k][idx]) begin
            e.flags = 3'b010;
          end else begin
            e.flags = 3'b100;
            m_data[k][p] = m_regs[k][idx];
          end
        end
        e.inst = k; e.port = p; e.idx = m_idx[k][p]; e.data = m_data[k][p];
        sb.push_back(e);
      end
      if (WR_EN && int'(N_REG_W) < depth_m[k]) begin
        m_regs[k][N_REG_W] = WR_DATA;
        m_lock[k][N_REG_W] = 1'b0;
      end
      if (LOCK_EN && int'(N_REG_L) < depth_m[k]) m_lock[k][N_REG_L] = 1'b1;
    end
    $display("txn %0d: wr=%b/%0d/%h lk=%b/%0d rdA=%b/%0d rdB=%b/%0d",
             txn, WR_EN, N_REG_W, WR_DATA, LOCK_EN, N_REG_L, RD_EN_A, N_REG_A, RD_EN_B, N_REG_B);
    txn++;
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("t%0d_i%0dp%0d_data", txn, e.inst, e.port), {16'b0, o_data[e.inst][e.port]}, {16'b0, e.data});
      check($sformatf("t%0d_i%0dp%0d_idx", txn, e.inst, e.port), {29'b0, o_idx[e.inst][e.port]}, {29'b0, e.idx});
      check($sformatf("t%0d_i%0dp%0d_flags", txn, e.inst, e.port),
            {29'b0, o_v[e.inst][e.port], o_b[e.inst][e.port], o_e[e.inst][e.port]}, {29'b0, e.flags});
    end
    check($sformatf("t%0d_map0", txn), {24'b0, map0}, {24'b0, m_lock[0]});
    check($sformatf("t%0d_map1", txn), {26'b0, map1}, {24'b0, m_lock[1]});
  endtask

  logic [15:0] wvals [8] = '{16'h6535, 16'h1a2b, 16'h3c4d, 16'h5e6f,
                             16'h7081, 16'h92a3, 16'hb4c5, 16'h808d};

  initial begin
    RESET_N = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RESET_N = 1'b1;

    // bypass on reg3 (still zero) via port B
    WR_EN = 1; N_REG_W = 3; WR_DATA = 16'habcd; RD_EN_B = 1; N_REG_B = 3;
    tick();
    idle();

    // write all registers, then step port A up and port B down
    for (int i = 0; i < 8; i++) begin
      WR_EN = 1; N_REG_W = 3'(i); WR_DATA = wvals[i];
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      RD_EN_A = 1; N_REG_A = 3'(i); RD_EN_B = 1; N_REG_B = 3'(7 - i);
      tick();
    end
    idle();
    tick();  // flags drop, data holds

    // lock reg5, read busy, unlock by write, read valid
    LOCK_EN = 1; N_REG_L = 5;
    tick();
    idle();
    RD_EN_A = 1; N_REG_A = 5;
    tick();
    check("lock_map", {24'b0, map0}, 32'h20);
    idle();
    WR_EN = 1; N_REG_W = 5; WR_DATA = 16'h1234;
    tick();
    idle();
    RD_EN_A = 1; N_REG_A = 5;
    tick();
    check("unlock_data", {16'b0, o_data[0][0]}, 32'h1234);

    // simultaneous lock and write on reg2: lock wins, data stored
    idle();
    WR_EN = 1; N_REG_W = 2; WR_DATA = 16'h5a5a; LOCK_EN = 1; N_REG_L = 2;
    tick();
    check("lockwr_map2", {31'b0, map0[2]}, 32'h1);
    check("lockwr_reg2", {16'b0, dut.regs_q[2]}, 32'h5a5a);
    idle();
    RD_EN_B = 1; N_REG_B = 2;
    tick();

    // out of range for the DEPTH=6 instance
    idle();
    WR_EN = 1; N_REG_W = 6; WR_DATA = 16'hbeef; LOCK_EN = 1; N_REG_L = 7;
    tick();
    idle();
    RD_EN_A = 1; N_REG_A = 7; RD_EN_B = 1; N_REG_B = 6;
    tick();
    check("oor_errA", {31'b0, o_e[1][0]}, 32'h1);
    check("oor_dataA", {16'b0, o_data[1][0]}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      RD_EN_A = 1; N_REG_A = 3'(i); RD_EN_B = 0;
      tick();
    end

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      WR_EN   = ($urandom_range(0, 2) == 0);
      N_REG_W = 3'($urandom_range(0, 7));
      WR_DATA = 16'($urandom());
      LOCK_EN = ($urandom_range(0, 3) == 0);
      N_REG_L = 3'($urandom_range(0, 7));
      RD_EN_A = ($urandom_range(0, 3) != 0);
      N_REG_A = 3'($urandom_range(0, 7));
      RD_EN_B = ($urandom_range(0, 3) != 0);
      N_REG_B = 3'($urandom_range(0, 7));
      tick();
    end

    // reset between edges while a read result is valid
    idle();
    RD_EN_A = 1; N_REG_A = 1;
    tick();
    RESET_N = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    model_reset();
    #1;
    RESET_N = 1'b1;
    RD_EN_A = 1; N_REG_A = 0;
    tick();
    check("postrst_valid", {31'b0, o_v[0][0]}, 32'h1);
    check("postrst_data", {16'b0, o_data[0][0]}, 32'h0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
